// File: rtl/axis_ul_route_stage.sv
// Per-region ingress stage ahead of the vFPGA switch: latches routing control at packet start,
// stamps tdest, buffers beats in a FWFT FIFO and drops packets to an invalid/disabled destination.
// Optional fwd_cnt/drop_cnt statistics outputs are built when AXIS_ROUTE_STATS_EN is defined.
module axis_ul_route_stage #(
    parameter int N_ID          = 4,
    parameter int FIFO_DEPTH    = 16,
    parameter int DEST_BITS     = 2,
    parameter int AXI_DATA_BITS = 64,
    parameter int PID_BITS      = 6
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [7:0]                 io_ctrl,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic [AXI_DATA_BITS-1:0]   s_tdata,
    input  logic [AXI_DATA_BITS/8-1:0] s_tkeep,
    input  logic                       s_tlast,
    input  logic [PID_BITS-1:0]        s_tid,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [AXI_DATA_BITS-1:0]   m_tdata,
    output logic [AXI_DATA_BITS/8-1:0] m_tkeep,
    output logic                       m_tlast,
    output logic [PID_BITS-1:0]        m_tid,
    output logic [DEST_BITS-1:0]       m_tdest,
    output logic                       drop_pkt
`ifdef AXIS_ROUTE_STATS_EN
    ,
    output logic [31:0]                fwd_cnt,
    output logic [31:0]                drop_cnt
`endif
);

    localparam int KEEP_BITS = AXI_DATA_BITS / 8;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int ENT_W     = AXI_DATA_BITS + KEEP_BITS + 1 + PID_BITS + DEST_BITS;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FWD  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]           state_r;
    logic [1:0]           state_nxt_s;
    logic [DEST_BITS-1:0] dest_r;
    logic [DEST_BITS-1:0] wr_dest_s;
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_nxt_s;
    logic [CNT_W-1:0]     count_r;
    logic [CNT_W-1:0]     count_nxt_s;
    logic                 ready_r;
    logic                 valid_r;
    logic                 drop_r;
    logic [ENT_W-1:0]     head_r;
    logic [ENT_W-1:0]     head_nxt_s;
    logic [ENT_W-1:0]     wr_entry_s;
    logic [ENT_W-1:0]     mem_r [FIFO_DEPTH];
    logic                 accept_s;
    logic                 verdict_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 drop_evt_s;
    logic                 unused_ctrl_s;

    assign unused_ctrl_s = ^io_ctrl[7:3];

    // Packet FSM: verdict at packet start, then forward or discard until tlast
    always_comb begin
        accept_s    = s_tvalid && ready_r;
        verdict_s   = io_ctrl[0] && (32'(io_ctrl[2:1]) < 32'(N_ID));
        state_nxt_s = state_r;
        push_s      = 1'b0;
        drop_evt_s  = 1'b0;
        wr_dest_s   = dest_r;
        case (state_r)
            ST_IDLE: begin
                wr_dest_s = DEST_BITS'(io_ctrl[2:1]);
                if (accept_s && verdict_s) begin
                    push_s      = 1'b1;
                    state_nxt_s = s_tlast ? ST_IDLE : ST_FWD;
                end else if (accept_s) begin
                    drop_evt_s  = s_tlast;
                    state_nxt_s = s_tlast ? ST_IDLE : ST_DROP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FWD: begin
                push_s = accept_s;
                if (accept_s && s_tlast) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_FWD;
                end
            end
            ST_DROP: begin
                if (accept_s && s_tlast) begin
                    drop_evt_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping; the next head bypasses the array when the pushed beat becomes head
    always_comb begin
        pop_s        = valid_r && m_tready;
        rd_ptr_nxt_s = pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
        wr_entry_s   = {s_tdata, s_tkeep, s_tlast, s_tid, wr_dest_s};
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
        if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = wr_entry_s;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Control state, pointers and registered outputs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r  <= ST_IDLE;
            dest_r   <= {DEST_BITS{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            ready_r  <= 1'b0;
            valid_r  <= 1'b0;
            drop_r   <= 1'b0;
            head_r   <= {ENT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_IDLE) && accept_s) begin
                dest_r <= DEST_BITS'(io_ctrl[2:1]);
            end else begin
                dest_r <= dest_r;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            ready_r  <= (state_nxt_s == ST_DROP) || (count_nxt_s != CNT_W'(FIFO_DEPTH));
            valid_r  <= (count_nxt_s != {CNT_W{1'b0}});
            drop_r   <= drop_evt_s;
            // Head only reloads while data remains, so m_* hold their last value when empty
            if (count_nxt_s != {CNT_W{1'b0}}) begin
                head_r <= head_nxt_s;
            end else begin
                head_r <= head_r;
            end
        end
    end

    // Beat storage array, written on push only
    always_ff @(posedge aclk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_entry_s;
        end
    end

    assign s_tready = ready_r;
    assign m_tvalid = valid_r;
    assign drop_pkt = drop_r;
    assign {m_tdata, m_tkeep, m_tlast, m_tid, m_tdest} = head_r;

`ifdef AXIS_ROUTE_STATS_EN
    logic [31:0] fwd_cnt_r;
    logic [31:0] drop_cnt_r;

    // Saturating forwarded/dropped packet counters
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            fwd_cnt_r  <= 32'd0;
            drop_cnt_r <= 32'd0;
        end else begin
            if (pop_s && m_tlast && (fwd_cnt_r != 32'hFFFF_FFFF)) begin
                fwd_cnt_r <= fwd_cnt_r + 32'd1;
            end else begin
                fwd_cnt_r <= fwd_cnt_r;
            end
            if (drop_r && (drop_cnt_r != 32'hFFFF_FFFF)) begin
                drop_cnt_r <= drop_cnt_r + 32'd1;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    assign fwd_cnt  = fwd_cnt_r;
    assign drop_cnt = drop_cnt_r;
`endif

endmodule

// File: tb/tb_axis_ul_route_stage.sv
// Self-checking bench for axis_ul_route_stage: directed scenarios plus randomized packets,
// checked against a packet-level scoreboard of expected output beats and drop pulses.
module tb_axis_ul_route_stage;

    localparam int N_ID = 2;
    localparam int FIFO_DEPTH = 16;
    localparam int DEST_BITS = 2;
    localparam int DW = 32;
    localparam int PW = 4;

    logic              clk;
    logic              aresetn;
    logic [7:0]        io_ctrl;
    logic              s_tvalid;
    logic              s_tready;
    logic [DW-1:0]     s_tdata;
    logic [DW/8-1:0]   s_tkeep;
    logic              s_tlast;
    logic [PW-1:0]     s_tid;
    logic              m_tvalid;
    logic              m_tready;
    logic [DW-1:0]     m_tdata;
    logic [DW/8-1:0]   m_tkeep;
    logic              m_tlast;
    logic [PW-1:0]     m_tid;
    logic [DEST_BITS-1:0] m_tdest;
    logic              drop_pkt;
`ifdef AXIS_ROUTE_STATS_EN
    logic [31:0]       fwd_cnt;
    logic [31:0]       drop_cnt;
`endif

    axis_ul_route_stage #(
        .N_ID(N_ID), .FIFO_DEPTH(FIFO_DEPTH), .DEST_BITS(DEST_BITS),
        .AXI_DATA_BITS(DW), .PID_BITS(PW)
    ) dut (
        .aclk(clk), .aresetn(aresetn), .io_ctrl(io_ctrl),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
        .s_tlast(s_tlast), .s_tid(s_tid),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
        .m_tlast(m_tlast), .m_tid(m_tid), .m_tdest(m_tdest),
        .drop_pkt(drop_pkt)
`ifdef AXIS_ROUTE_STATS_EN
        ,
        .fwd_cnt(fwd_cnt), .drop_cnt(drop_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int tests, fails, cyc, acc_cnt, out_cnt, drop_seen;
    int exp_wr, exp_rd;
    logic [63:0] exp_mem [4096];
    bit pkt_drop;
    logic [1:0] pkt_dest;
    bit last_acc, drop_due, stall_prev, rand_rdy, ready_low_seen, valid_seen;
    logic [63:0] stall_bus;
    int acc_cyc, valid_cyc, pop_first, pop_last;
    int base_out, base_drop, base_acc;
    logic [63:0] m_bus;

    assign m_bus = {21'd0, m_tdata, m_tkeep, m_tlast, m_tid, m_tdest};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observe one cycle at the negedge: accepts, pops, drop pulses, output stability
    task automatic monitor();
        last_acc = aresetn && s_tvalid && s_tready;
        if (last_acc) begin
            acc_cnt++;
            if (acc_cyc < 0) acc_cyc = cyc;
        end
        if (s_tvalid && !s_tready) ready_low_seen = 1'b1;
        if (m_tvalid) begin
            valid_seen = 1'b1;
            if (valid_cyc < 0) valid_cyc = cyc;
        end
        if (drop_pkt || drop_due) check("drop_pkt", 64'(drop_pkt), 64'(drop_due));
        if (drop_pkt) drop_seen++;
        drop_due = last_acc && s_tlast && pkt_drop;
        if (stall_prev && m_tvalid) check("hold", m_bus, stall_bus);
        stall_prev = m_tvalid && !m_tready;
        stall_bus = m_bus;
        if (m_tvalid && m_tready) begin
            out_cnt++;
            if (pop_first < 0) pop_first = cyc;
            pop_last = cyc;
            if (exp_rd == exp_wr) begin
                check("unexpected_beat", 64'(m_tvalid), 64'd0);
            end else begin
                check("beat", m_bus, exp_mem[exp_rd % 4096]);
                exp_rd++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        if (rand_rdy) m_tready = 1'($urandom);
    endtask

    task automatic start_pkt();
        pkt_drop = !(io_ctrl[0] && (int'(io_ctrl[2:1]) < N_ID));
        pkt_dest = io_ctrl[2:1];
    endtask

    task automatic present_beat(input logic [PW-1:0] tid, input bit last);
        s_tdata  = $urandom;
        s_tkeep  = 4'($urandom);
        s_tlast  = last;
        s_tid    = tid;
        s_tvalid = 1'b1;
        if (!pkt_drop) begin
            exp_mem[exp_wr % 4096] = {21'd0, s_tdata, s_tkeep, last, tid, pkt_dest};
            exp_wr++;
        end
    endtask

    task automatic wait_accept();
        last_acc = 1'b0;
        for (int w = 0; w < 300; w++) begin
            tick();
            if (last_acc) break;
        end
        check("accept_in_time", 64'(last_acc), 64'd1);
    endtask

    task automatic send_pkt(input int n, input logic [PW-1:0] tid, input bit gaps,
                            input int change_at, input logic [7:0] new_ctrl);
        start_pkt();
        for (int b = 0; b < n; b++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                s_tvalid = 1'b0;
                tick();
            end
            present_beat(tid, b == n - 1);
            wait_accept();
            if (b == change_at) io_ctrl = new_ctrl;
        end
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        for (int w = 0; w < 600 && ((exp_rd != exp_wr) || m_tvalid); w++) tick();
        repeat (2) tick();
        check("drain", 64'(exp_wr - exp_rd), 64'd0);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        #1;
        check("rst_s_tready", 64'(s_tready), 64'd0);
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_drop_pkt", 64'(drop_pkt), 64'd0);
        check("rst_m_bus", m_bus, 64'd0);
        s_tvalid = 1'b0;
        exp_rd = exp_wr;
        drop_due = 1'b0;
        stall_prev = 1'b0;
        last_acc = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        aresetn = 1'b1;
        #1;
        check("rel_s_tready_before_edge", 64'(s_tready), 64'd0);
        @(posedge clk);
        #1;
        cyc++;
        check("rel_s_tready_cycle1", 64'(s_tready), 64'd1);
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0; acc_cnt = 0; out_cnt = 0; drop_seen = 0;
        exp_wr = 0; exp_rd = 0; pkt_drop = 1'b0; pkt_dest = 2'd0;
        drop_due = 1'b0; stall_prev = 1'b0; rand_rdy = 1'b0; stall_bus = 64'd0;
        acc_cyc = 0; valid_cyc = 0; pop_first = 0; pop_last = 0;
        aresetn = 1'b1; io_ctrl = 8'h00; m_tready = 1'b0;
        s_tvalid = 1'b0; s_tdata = 32'd0; s_tkeep = 4'd0; s_tlast = 1'b0; s_tid = 4'd0;
        #3;
        do_reset();

        // Forwarding: enable, dest 1, 4 beats tid 5
        io_ctrl = 8'h03; m_tready = 1'b1;
        acc_cyc = -1; valid_cyc = -1; base_out = out_cnt; base_drop = drop_seen;
        send_pkt(4, 4'd5, 1'b0, -1, 8'h00);
        drain();
        check("fwd_beats", 64'(out_cnt - base_out), 64'd4);
        check("fwd_latency", 64'(valid_cyc - acc_cyc), 64'd1);
        check("fwd_no_drop", 64'(drop_seen - base_drop), 64'd0);

        // Drop: disabled route, 3 beats
        io_ctrl = 8'h00; ready_low_seen = 1'b0; valid_seen = 1'b0;
        base_out = out_cnt; base_drop = drop_seen;
        send_pkt(3, 4'd1, 1'b0, -1, 8'h00);
        repeat (3) tick();
        check("drop_ready_high", 64'(ready_low_seen), 64'd0);
        check("drop_no_valid", 64'(valid_seen), 64'd0);
        check("drop_pulses", 64'(drop_seen - base_drop), 64'd1);

        // Enabled but destination out of range, single-beat packet
        io_ctrl = 8'h05; base_drop = drop_seen; base_out = out_cnt;
        send_pkt(1, 4'd2, 1'b0, -1, 8'h00);
        repeat (3) tick();
        check("baddest_pulses", 64'(drop_seen - base_drop), 64'd1);
        check("baddest_no_out", 64'(out_cnt - base_out), 64'd0);

        // Mid-packet control change has no effect until the next packet
        io_ctrl = 8'h01; base_out = out_cnt;
        send_pkt(8, 4'd2, 1'b0, 1, 8'h03);
        send_pkt(2, 4'd3, 1'b0, -1, 8'h00);
        drain();
        check("midchg_beats", 64'(out_cnt - base_out), 64'd10);

        // Backpressure until full, then release
        io_ctrl = 8'h03; m_tready = 1'b0; base_out = out_cnt; base_acc = acc_cnt;
        start_pkt();
        for (int b = 0; b < 16; b++) begin
            present_beat(4'd7, 1'b0);
            wait_accept();
        end
        present_beat(4'd7, 1'b0);
        repeat (4) tick();
        check("full_accepted", 64'(acc_cnt - base_acc), 64'd16);
        check("full_s_tready", 64'(s_tready), 64'd0);
        check("full_m_tvalid", 64'(m_tvalid), 64'd1);
        pop_first = -1;
        m_tready = 1'b1;
        wait_accept();
        for (int b = 17; b < 20; b++) begin
            present_beat(4'd7, b == 19);
            wait_accept();
        end
        s_tvalid = 1'b0;
        drain();
        check("bp_beats", 64'(out_cnt - base_out), 64'd20);
        check("bp_no_gaps", 64'(pop_last - pop_first), 64'd19);

        // Reset in the middle of a packet
        io_ctrl = 8'h03; m_tready = 1'b0;
        start_pkt();
        for (int b = 0; b < 5; b++) begin
            present_beat(4'd4, 1'b0);
            wait_accept();
        end
        check("pre_rst_m_tvalid", 64'(m_tvalid), 64'd1);
        do_reset();
        m_tready = 1'b1; base_out = out_cnt;
        send_pkt(2, 4'd6, 1'b0, -1, 8'h00);
        drain();
        check("post_rst_beats", 64'(out_cnt - base_out), 64'd2);

        // Randomized packets, control and backpressure
        rand_rdy = 1'b1;
        for (int p = 0; p < 40; p++) begin
            int n;
            io_ctrl = 8'($urandom);
            io_ctrl[0] = ($urandom_range(0, 3) != 0);
            n = $urandom_range(1, 6);
            send_pkt(n, 4'($urandom), 1'b1, $urandom_range(0, n), 8'($urandom));
        end
        rand_rdy = 1'b0;
        m_tready = 1'b1;
        drain();

`ifdef AXIS_ROUTE_STATS_EN
        do_reset();
        io_ctrl = 8'h03;
        for (int p = 0; p < 3; p++) send_pkt(2, 4'd1, 1'b0, -1, 8'h00);
        io_ctrl = 8'h00;
        for (int p = 0; p < 2; p++) send_pkt(2, 4'd1, 1'b0, -1, 8'h00);
        drain();
        repeat (3) tick();
        check("fwd_cnt", 64'(fwd_cnt), 64'd3);
        check("drop_cnt", 64'(drop_cnt), 64'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
